// File: rtl/reduce_mux_n.sv
// Output-port mux: per-channel FIFOs, priority arbitration, and a reduction table
// that combines contributions per index. REDUCE_MUX_RR_EN enables round-robin tie-break.
module reduce_mux_n #(
    parameter int NumPorts        = 7,
    parameter int DataWidth       = 256,
    parameter int FIFODepth       = 4,
    parameter int PriorityPos     = 152,
    parameter int PriorityWidth   = 8,
    parameter int ReductionBitPos = 254,
    parameter int IndexPos        = 128,
    parameter int IndexWidth      = 8,
    parameter int WeightPos       = 144,
    parameter int WeightWidth     = 8,
    parameter int PayloadLen      = 128,
    parameter int CntWidth        = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NumPorts*DataWidth-1:0] in,
    input  logic [NumPorts-1:0]           in_stall,
    output logic [NumPorts-1:0]           in_avail,
    input  logic                          out_stall,
    input  logic                          cfg_we,
    input  logic [IndexWidth-1:0]         cfg_index,
    input  logic [CntWidth-1:0]           cfg_expect,
    output logic [DataWidth-1:0]          out,
    output logic                          send
);
    localparam int PW      = $clog2(NumPorts);
    localparam int AW      = $clog2(FIFODepth);
    localparam int Entries = 1 << IndexWidth;

    typedef logic [DataWidth-1:0] pkt_t;

    pkt_t                     fifo_mem_q [NumPorts][FIFODepth];
    logic [AW:0]              wr_ptr_q   [NumPorts];
    logic [AW:0]              rd_ptr_q   [NumPorts];
    pkt_t                     head       [NumPorts];
    logic [PriorityWidth-1:0] pri        [NumPorts];
    logic [NumPorts-1:0]      empty, full, push, pop;

    logic                     frozen;
    logic                     gnt_vld;
    logic [PW-1:0]            gnt_idx;
    logic [PriorityWidth-1:0] best_pri;

    logic                     vld_p0_q, vld_p1_q;
    pkt_t                     pkt_p0_q, pkt_p1_q;
    logic [CntWidth-1:0]      exp_p1_q, cnt_p1_q;
    logic [WeightWidth-1:0]   wacc_p1_q;
    logic [PayloadLen-1:0]    pacc_p1_q;
    pkt_t                     out_q, out_d;

    logic [CntWidth-1:0]      exp_tab_q  [Entries];
    logic [CntWidth-1:0]      cnt_tab_q  [Entries];
    logic [WeightWidth-1:0]   wacc_tab_q [Entries];
    logic [PayloadLen-1:0]    pacc_tab_q [Entries];

    logic [IndexWidth-1:0]    idx_p0, idx_p1;
    logic                     is_red_p1, done_p1, wb_we;
    logic [CntWidth:0]        n_p1;
    logic [WeightWidth-1:0]   w_sum;
    logic [PayloadLen-1:0]    p_sum;
    logic [CntWidth-1:0]      cnt_d;
    logic [WeightWidth-1:0]   wacc_d;
    logic [PayloadLen-1:0]    pacc_d;

    // A valid packet held on out against a stalled link freezes the whole pipe.
    assign frozen   = out_q[DataWidth-1] && out_stall;
    assign out      = out_q;
    assign send     = out_q[DataWidth-1];
    assign in_avail = ~full;
    assign idx_p0   = pkt_p0_q[IndexPos +: IndexWidth];
    assign idx_p1   = pkt_p1_q[IndexPos +: IndexWidth];

    always_comb begin
        for (int i = 0; i < NumPorts; i++) begin
            head[i]  = fifo_mem_q[i][rd_ptr_q[i][AW-1:0]];
            pri[i]   = head[i][PriorityPos +: PriorityWidth];
            empty[i] = (wr_ptr_q[i] == rd_ptr_q[i]);
            full[i]  = (wr_ptr_q[i][AW] != rd_ptr_q[i][AW]) &&
                       (wr_ptr_q[i][AW-1:0] == rd_ptr_q[i][AW-1:0]);
        end
    end

    // A full FIFO still accepts a write when its head is popped in the same cycle.
    always_comb begin
        for (int i = 0; i < NumPorts; i++) begin
            pop[i]  = gnt_vld && !frozen && (gnt_idx == PW'(i));
            push[i] = !in_stall[i] && in[i*DataWidth + DataWidth-1] && (!full[i] || pop[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NumPorts; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NumPorts; i++) begin
                if (push[i]) begin
                    fifo_mem_q[i][wr_ptr_q[i][AW-1:0]] <= in[i*DataWidth +: DataWidth];
                    wr_ptr_q[i] <= wr_ptr_q[i] + 1'b1;
                end
                if (pop[i]) begin
                    rd_ptr_q[i] <= rd_ptr_q[i] + 1'b1;
                end
            end
        end
    end

`ifdef REDUCE_MUX_RR_EN
    logic [PW-1:0] rr_ptr_q, rr_ptr_d;

    assign rr_ptr_d = (gnt_idx == PW'(NumPorts-1)) ? '0 : gnt_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
        end else if (gnt_vld && !frozen) begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

    // Scan in tie-break order; strict '>' keeps the first port seen at the top priority.
    always_comb begin
        int j;
        j        = 0;
        gnt_vld  = 1'b0;
        gnt_idx  = '0;
        best_pri = '0;
        for (int k = 0; k < NumPorts; k++) begin
`ifdef REDUCE_MUX_RR_EN
            j = int'(rr_ptr_q) + k;
            if (j >= NumPorts) j = j - NumPorts;
`else
            j = k;
`endif
            if (!empty[j] && (!gnt_vld || pri[j] > best_pri)) begin
                gnt_vld  = 1'b1;
                gnt_idx  = PW'(j);
                best_pri = pri[j];
            end
        end
    end

    always_comb begin
        is_red_p1 = pkt_p1_q[ReductionBitPos];
        n_p1      = {1'b0, cnt_p1_q} + 1'b1;
        w_sum     = wacc_p1_q + pkt_p1_q[WeightPos +: WeightWidth];
        p_sum     = pacc_p1_q + pkt_p1_q[PayloadLen-1:0];
        done_p1   = (n_p1 >= {1'b0, exp_p1_q});
        wb_we     = vld_p1_q && is_red_p1 && !frozen;
        cnt_d     = done_p1 ? '0 : n_p1[CntWidth-1:0];
        wacc_d    = done_p1 ? '0 : w_sum;
        pacc_d    = done_p1 ? '0 : p_sum;
        out_d     = '0;
        if (vld_p1_q) begin
            if (!is_red_p1) begin
                out_d = pkt_p1_q;
            end else if (done_p1) begin
                out_d = {pkt_p1_q[DataWidth-1:WeightPos+WeightWidth], w_sum,
                         pkt_p1_q[WeightPos-1:PayloadLen], p_sum};
            end
        end
    end

    // FR -> RR -> WB -> out stage boundaries
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0_q <= 1'b0;
            vld_p1_q <= 1'b0;
            out_q    <= '0;
        end else if (!frozen) begin
            vld_p0_q <= gnt_vld;
            vld_p1_q <= vld_p0_q;
            out_q    <= out_d;
        end
    end

    // RR read forwards the concurrent WB write so back-to-back contributions chain.
    always_ff @(posedge clk) begin
        if (!frozen) begin
            pkt_p0_q <= head[gnt_idx];
            pkt_p1_q <= pkt_p0_q;
            exp_p1_q <= (cfg_we && cfg_index == idx_p0) ? cfg_expect : exp_tab_q[idx_p0];
            if (wb_we && idx_p1 == idx_p0) begin
                cnt_p1_q  <= cnt_d;
                wacc_p1_q <= wacc_d;
                pacc_p1_q <= pacc_d;
            end else begin
                cnt_p1_q  <= cnt_tab_q[idx_p0];
                wacc_p1_q <= wacc_tab_q[idx_p0];
                pacc_p1_q <= pacc_tab_q[idx_p0];
            end
        end
    end

    // Expect is owned by the config port; WB only updates count and accumulators.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int e = 0; e < Entries; e++) begin
                exp_tab_q[e]  <= '0;
                cnt_tab_q[e]  <= '0;
                wacc_tab_q[e] <= '0;
                pacc_tab_q[e] <= '0;
            end
        end else begin
            if (wb_we) begin
                cnt_tab_q[idx_p1]  <= cnt_d;
                wacc_tab_q[idx_p1] <= wacc_d;
                pacc_tab_q[idx_p1] <= pacc_d;
            end
            if (cfg_we) begin
                exp_tab_q[cfg_index] <= cfg_expect;
            end
        end
    end
endmodule
